// File: rtl/bit_table_writer.sv
// Bit table [D0][D1][D2] with single-bit handshake writes, bulk serial load and a registered read port.
// Optional BIT_TABLE_WRITER_PARITY_EN adds a registered XOR-of-all-bits output.
module bit_table_writer #(
  parameter int D0 = 2,
  parameter int D1 = 3,
  parameter int D2 = 4,
  localparam int IW = (D0 > 1) ? $clog2(D0) : 1,
  localparam int JW = (D1 > 1) ? $clog2(D1) : 1,
  localparam int KW = (D2 > 1) ? $clog2(D2) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [IW-1:0] wr_i,
  input  logic [JW-1:0] wr_j,
  input  logic [KW-1:0] wr_k,
  input  logic          wr_bit,
  input  logic          load_start,
  input  logic          ser_valid,
  input  logic          ser_bit,
  input  logic [IW-1:0] rd_i,
  input  logic [JW-1:0] rd_j,
  input  logic [KW-1:0] rd_k,
  output logic          rd_bit,
  output logic          busy,
  output logic          done,
  output logic          err,
`ifdef BIT_TABLE_WRITER_PARITY_EN
  output logic          parity,
`endif
  output logic          table_q [D0-1:0][D1-1:0][D2-1:0]
);

  localparam int N  = D0 * D1 * D2;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t        state, state_nx;
  logic [N-1:0]  tbl;
  logic [CW-1:0] cnt;
  logic          rdy_q;
  logic          wr_fire, wr_inr, rd_inr;
  logic [CW-1:0] wr_f, rd_f, ser_f;

  assign wr_inr  = (32'(wr_i) < D0) && (32'(wr_j) < D1) && (32'(wr_k) < D2);
  assign rd_inr  = (32'(rd_i) < D0) && (32'(rd_j) < D1) && (32'(rd_k) < D2);
  assign wr_f    = CW'(32'(wr_i) * D1 * D2 + 32'(wr_j) * D2 + 32'(wr_k));
  assign rd_f    = CW'(32'(rd_i) * D1 * D2 + 32'(rd_j) * D2 + 32'(rd_k));
  // Serial stream runs in aggregate-literal order: first bit lands at the highest flat index.
  assign ser_f   = CW'(N - 1) - cnt;
  assign wr_fire = wr_valid && wr_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (load_start) state_nx = LOAD;
      LOAD:    if (ser_valid && cnt == CW'(N - 1)) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // rdy_q holds wr_ready low until the first clock after reset release.
  always_comb begin
    wr_ready = (state == IDLE) && rdy_q;
    busy     = (state == LOAD);
    done     = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tbl    <= '0;
      cnt    <= '0;
      rdy_q  <= 1'b0;
      err    <= 1'b0;
      rd_bit <= 1'b0;
    end else begin
      rdy_q  <= 1'b1;
      rd_bit <= rd_inr ? tbl[rd_f] : 1'b0;
      if (wr_fire) begin
        if (wr_inr) tbl[wr_f] <= wr_bit;
        else        err       <= 1'b1;
      end
      if (load_start && state != IDLE) err <= 1'b1;
      if (state == IDLE && load_start) begin
        cnt <= '0;
      end else if (state == LOAD && ser_valid) begin
        tbl[ser_f] <= ser_bit;
        cnt        <= cnt + 1'b1;
      end
    end
  end

`ifdef BIT_TABLE_WRITER_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) parity <= 1'b0;
    else        parity <= ^tbl;
  end
`endif

  for (genvar gi = 0; gi < D0; gi++) begin : g_i
    for (genvar gj = 0; gj < D1; gj++) begin : g_j
      for (genvar gk = 0; gk < D2; gk++) begin : g_k
        assign table_q[gi][gj][gk] = tbl[gi*D1*D2 + gj*D2 + gk];
      end
    end
  end

endmodule

// File: tb/tb_bit_table_writer.sv
// Directed bench for bit_table_writer (2x3x4): writes, serial load, reads, errors and reset abort.
module tb_bit_table_writer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_valid, wr_ready, wr_bit;
  logic [0:0] wr_i, rd_i;
  logic [1:0] wr_j, wr_k, rd_j, rd_k;
  logic       load_start, ser_valid, ser_bit;
  logic       rd_bit, busy, done, err;
`ifdef BIT_TABLE_WRITER_PARITY_EN
  logic       parity;
`endif
  logic       tq [1:0][2:0][3:0];
  logic [23:0] tq_flat, pat, exp_ld;

  int checks = 0;
  int failures = 0;

  bit_table_writer #(.D0(2), .D1(3), .D2(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_i(wr_i), .wr_j(wr_j), .wr_k(wr_k), .wr_bit(wr_bit),
    .load_start(load_start), .ser_valid(ser_valid), .ser_bit(ser_bit),
    .rd_i(rd_i), .rd_j(rd_j), .rd_k(rd_k), .rd_bit(rd_bit),
    .busy(busy), .done(done), .err(err),
`ifdef BIT_TABLE_WRITER_PARITY_EN
    .parity(parity),
`endif
    .table_q(tq)
  );

  always #5 clk = ~clk;

  always_comb begin
    tq_flat = '0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 3; j++)
        for (int k = 0; k < 4; k++)
          tq_flat[i*12 + j*4 + k] = tq[i][j][k];
  end

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; wr_valid = 0; wr_bit = 0; wr_i = 0; wr_j = 0; wr_k = 0;
    load_start = 0; ser_valid = 0; ser_bit = 0; rd_i = 0; rd_j = 0; rd_k = 0;
    // Stream: 0,1,0,1 then 0,1,1,1 five times; count c lands at flat index 23-c.
    for (int c = 0; c < 24; c++) begin
      pat[c] = (c < 4) ? (c % 2 == 1) : ((c - 4) % 4 != 0);
      exp_ld[23 - c] = pat[c];
    end

    tick(); tick();
    chk("rst_wr_ready", wr_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_rd_bit", rd_bit, 1'b0);
    chk("rst_table", tq_flat, 24'h0);
    #2 rst_n = 1'b1;
    tick();
    chk("ready_after_rst", wr_ready, 1'b1);

    // single write [1][2][3]=1
    wr_valid = 1; wr_i = 1; wr_j = 2; wr_k = 3; wr_bit = 1;
    tick();
    wr_valid = 0;
    chk("single_write_bit", tq[1][2][3], 1'b1);
    chk("single_write_table", tq_flat, 24'h800000);
    rd_i = 1; rd_j = 2; rd_k = 3;
    tick();
`ifdef BIT_TABLE_WRITER_PARITY_EN
    chk("parity_one", parity, 1'b1);
`endif
    chk("read_123", rd_bit, 1'b1);
    rd_j = 3;
    tick();
    chk("read_oor", rd_bit, 1'b0);

    // same-cycle read and write of [0][0][0] returns the old value
    rd_i = 0; rd_j = 0; rd_k = 0;
    wr_valid = 1; wr_i = 0; wr_j = 0; wr_k = 0; wr_bit = 1;
    tick();
    wr_valid = 0;
    chk("rw_collision_old", rd_bit, 1'b0);
    tick();
    chk("rw_collision_new", rd_bit, 1'b1);
`ifdef BIT_TABLE_WRITER_PARITY_EN
    chk("parity_two", parity, 1'b0);
`endif

    // out-of-range write (j=3) leaves table unchanged and sets sticky err
    chk("err_clear", err, 1'b0);
    wr_valid = 1; wr_i = 1; wr_j = 3; wr_k = 0; wr_bit = 1;
    tick();
    wr_valid = 0;
    chk("err_set", err, 1'b1);
    chk("err_table_same", tq_flat, 24'h800001);
    tick(); tick(); tick();
    chk("err_sticky", err, 1'b1);

    // async reset clears everything without a clock edge
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_err", err, 1'b0);
    chk("async_rst_table", tq_flat, 24'h0);
    chk("async_rst_ready", wr_ready, 1'b0);
    tick();
    #2 rst_n = 1'b1;
    tick();

    // write and load_start together; then write held during LOAD
    wr_valid = 1; wr_i = 1; wr_j = 0; wr_k = 3; wr_bit = 1; load_start = 1;
    tick();
    load_start = 0;
    chk("simul_write_landed", tq[1][0][3], 1'b1);
    chk("simul_busy", busy, 1'b1);
    chk("simul_ready_low", wr_ready, 1'b0);
    wr_i = 1; wr_j = 1; wr_k = 3; wr_bit = 1;
    for (int c = 0; c < 24; c++) begin
      ser_valid = 1; ser_bit = pat[c];
      tick();
      chk("load_ready_low", wr_ready, 1'b0);
    end
    ser_valid = 0;
    chk("load_done", done, 1'b1);
    chk("load_done_busy", busy, 1'b0);
    chk("held_write_blocked", tq[1][1][3], 1'b0);
    chk("load_table", tq_flat, exp_ld);
    tick();
    chk("done_one_cycle", done, 1'b0);
    chk("idle_ready", wr_ready, 1'b1);
    tick();
    wr_valid = 0;
    chk("held_write_lands", tq[1][1][3], 1'b1);

    rd_i = 0; rd_j = 0; rd_k = 2; tick();
    chk("P002", rd_bit, 1'b1);
    rd_i = 0; rd_j = 1; rd_k = 3; tick();
    chk("P013", rd_bit, 1'b0);
    rd_i = 1; rd_j = 2; rd_k = 1; tick();
    chk("P121", rd_bit, 1'b0);
    rd_i = 1; rd_j = 0; rd_k = 3; tick();
    chk("P103", rd_bit, 1'b0);

    // reset after 10 of 24 bits aborts the load
    load_start = 1; tick(); load_start = 0;
    for (int c = 0; c < 10; c++) begin
      ser_valid = 1; ser_bit = pat[c];
      tick();
    end
    ser_valid = 0;
    chk("abort_busy_before", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_table", tq_flat, 24'h0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    tick();
    #2 rst_n = 1'b1;
    tick();

    // fresh load; load_start mid-load is ignored but flags err
    load_start = 1; tick(); load_start = 0;
    for (int c = 0; c < 24; c++) begin
      ser_valid = 1; ser_bit = pat[c];
      load_start = (c == 5);
      tick();
      if (c == 5) begin
        chk("restart_err", err, 1'b1);
        chk("restart_busy", busy, 1'b1);
      end
    end
    ser_valid = 0; load_start = 0;
    chk("reload_done", done, 1'b1);
    chk("reload_table", tq_flat, exp_ld);
    tick();
    chk("reload_idle", busy, 1'b0);
`ifdef BIT_TABLE_WRITER_PARITY_EN
    chk("parity_load", parity, ^exp_ld);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
